// File: rtl/lsu_pkg.sv
// Shared encodings and width helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    W_BYTE   = 2'b00,
    W_HALF   = 2'b01,
    W_WORD   = 2'b10,
    W_DOUBLE = 2'b11
  } lsu_width_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  function automatic int nb_of(int xlen);
    return xlen / 8;
  endfunction

  function automatic int off_w_of(int xlen);
    return $clog2(xlen / 8);
  endfunction

  // True when an access of 2**width bytes at byte offset off spills past the bus word.
  function automatic logic crosses_nb(int nb, int off, logic [1:0] width);
    return (off + (1 << width)) > nb;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: beat masks, write-lane shifting and load assembly/extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [off_w_of(XLEN)-1:0] off,
  input  logic [1:0]                width,
  input  logic                      zero_ext,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata0,
  input  logic [XLEN-1:0]           rdata1,
  output logic [nb_of(XLEN)-1:0]    mask0,
  output logic [nb_of(XLEN)-1:0]    mask1,
  output logic [XLEN-1:0]           wdata0,
  output logic [XLEN-1:0]           wdata1,
  output logic [XLEN-1:0]           ld_data,
  output logic                      crosses
);
  localparam int NB = nb_of(XLEN);

  logic [2*NB-1:0]   size_mask;
  logic [2*NB-1:0]   lane_mask;
  logic [2*XLEN-1:0] wide_wdata;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep;
  logic              sign;

  always_comb begin
    size_mask = (2*NB)'(8'hFF);
    keep      = '1;
    sign      = 1'b0;
    case (width)
      W_BYTE: begin
        size_mask = (2*NB)'(8'h01);
        keep      = XLEN'(8'hFF);
        sign      = shifted[7];
      end
      W_HALF: begin
        size_mask = (2*NB)'(8'h03);
        keep      = XLEN'(16'hFFFF);
        sign      = shifted[15];
      end
      W_WORD: begin
        size_mask = (2*NB)'(8'h0F);
        keep      = XLEN'(32'hFFFF_FFFF);
        sign      = shifted[31];
      end
      default: ;
    endcase
  end

  // The double-width shift puts beat0 lanes in the low half and spill lanes in the high half.
  assign lane_mask  = size_mask << off;
  assign mask0      = lane_mask[NB-1:0];
  assign mask1      = lane_mask[2*NB-1:NB];
  assign crosses    = |mask1;

  assign wide_wdata = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
  assign wdata0     = wide_wdata[XLEN-1:0];
  assign wdata1     = wide_wdata[2*XLEN-1:XLEN];

  assign shifted    = XLEN'({rdata1, rdata0} >> {off, 3'b000});
  // Full-width access has keep all ones, so ~keep is zero and no extension happens.
  assign ld_data    = (shifted & keep) | ((sign && !zero_ext) ? ~keep : '0);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core request into one or two aligned bus beats and a response pulse.
// state | meaning
// IDLE  | ready for a request
// BEAT0 | first (or only) bus beat outstanding
// BEAT1 | spill beat for an access crossing the bus word
// RESP  | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_width,
  input  logic                    req_unsigned,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    resp_valid,
  output logic [XLEN-1:0]         resp_rdata,
  output logic                    resp_fault,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [XLEN-1:0]         bus_wdata,
  output logic [nb_of(XLEN)-1:0]  bus_mask,
  input  logic                    bus_ack,
  input  logic [XLEN-1:0]         bus_rdata
);
  localparam int NB   = nb_of(XLEN);
  localparam int OFFW = off_w_of(XLEN);

  localparam logic [1:0] IDLE  = S_IDLE;
  localparam logic [1:0] BEAT0 = S_BEAT0;
  localparam logic [1:0] BEAT1 = S_BEAT1;
  localparam logic [1:0] RESP  = S_RESP;

  logic [1:0]        state;
  logic              we_q;
  logic [1:0]        width_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              fault_q;
  logic [XLEN-1:0]   rd0_q;
  logic [XLEN-1:0]   rd1_q;

  logic              req_illegal;
  logic [NB-1:0]     mask0, mask1;
  logic [XLEN-1:0]   wdata0, wdata1, ld_data;
  logic              crosses;
  logic [ADDR_W-1:0] beat0_addr;

  assign req_illegal = (XLEN == 32 && req_width == W_DOUBLE) ||
                       (!SPLIT_MISALIGNED && crosses_nb(NB, int'(req_addr[OFFW-1:0]), req_width));

  lsu_align #(.XLEN(XLEN)) u_align (
    .off      (addr_q[OFFW-1:0]),
    .width    (width_q),
    .zero_ext (uns_q),
    .wdata    (wdata_q),
    .rdata0   (rd0_q),
    .rdata1   (rd1_q),
    .mask0    (mask0),
    .mask1    (mask1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ld_data  (ld_data),
    .crosses  (crosses)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            width_q <= req_width;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fault_q <= req_illegal;
            rd0_q   <= '0;
            rd1_q   <= '0;
            state   <= req_illegal ? RESP : BEAT0;
          end
        end
        BEAT0: begin
          if (bus_ack) begin
            rd0_q <= bus_rdata;
            state <= crosses ? BEAT1 : RESP;
          end
        end
        BEAT1: begin
          if (bus_ack) begin
            rd1_q <= bus_rdata;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode purely from registered state, so they hold steady while waiting for ack.
  assign beat0_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign req_ready  = (state == IDLE);
  assign bus_req    = (state == BEAT0) || (state == BEAT1);
  assign bus_we     = bus_req && we_q;
  assign bus_addr   = (state == BEAT1) ? beat0_addr + ADDR_W'(NB) : beat0_addr;
  assign bus_mask   = (state == BEAT0) ? mask0 : (state == BEAT1) ? mask1 : '0;
  assign bus_wdata  = (state == BEAT0) ? wdata0 : (state == BEAT1) ? wdata1 : '0;

  assign resp_valid = (state == RESP);
  assign resp_fault = resp_valid && fault_q;
  assign resp_rdata = (resp_valid && !we_q && !fault_q) ? ld_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: 32-bit split, 32-bit no-split and 64-bit instances.
module tb_load_store_unit;

  logic        clk, reset;
  logic        req_valid, req_we, req_unsigned, bus_ack;
  logic [1:0]  req_width, sel;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, bus_rdata;

  logic        rv_a, rv_b, rv_c;
  logic        rdy_a, rdy_b, rdy_c, vld_a, vld_b, vld_c, flt_a, flt_b, flt_c;
  logic        breq_a, breq_b, breq_c, bwe_a, bwe_b, bwe_c;
  logic [31:0] rd_a, rd_b, addr_a, addr_b, addr_c, wd_a, wd_b;
  logic [63:0] rd_c, wd_c;
  logic [3:0]  m_a, m_b;
  logic [7:0]  m_c;

  logic        v_ready, v_valid, v_fault, v_breq, v_bwe;
  logic [31:0] v_addr;
  logic [63:0] v_wdata, v_rdata;
  logic [7:0]  v_mask;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [1:0]  width;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rd0;
    logic [63:0] rd1;
    int          waits;
    int          beats;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [7:0]  m0;
    logic [7:0]  m1;
    logic [63:0] w0;
    logic [63:0] w1;
    logic        fault;
    logic [63:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  assign rv_a = req_valid && (sel == 2'd0);
  assign rv_b = req_valid && (sel == 2'd1);
  assign rv_c = req_valid && (sel == 2'd2);

  load_store_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_a (
    .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rdy_a), .req_we(req_we),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(vld_a), .resp_rdata(rd_a), .resp_fault(flt_a),
    .bus_req(breq_a), .bus_we(bwe_a), .bus_addr(addr_a), .bus_wdata(wd_a), .bus_mask(m_a),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata[31:0]));

  load_store_unit #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_b (
    .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(rdy_b), .req_we(req_we),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(vld_b), .resp_rdata(rd_b), .resp_fault(flt_b),
    .bus_req(breq_b), .bus_we(bwe_b), .bus_addr(addr_b), .bus_wdata(wd_b), .bus_mask(m_b),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata[31:0]));

  load_store_unit #(.XLEN(64), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_c (
    .clk(clk), .reset(reset), .req_valid(rv_c), .req_ready(rdy_c), .req_we(req_we),
    .req_width(req_width), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(vld_c), .resp_rdata(rd_c), .resp_fault(flt_c),
    .bus_req(breq_c), .bus_we(bwe_c), .bus_addr(addr_c), .bus_wdata(wd_c), .bus_mask(m_c),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata));

  always_comb begin
    v_ready = rdy_a; v_valid = vld_a; v_fault = flt_a; v_breq = breq_a; v_bwe = bwe_a;
    v_addr  = addr_a; v_wdata = {32'h0, wd_a}; v_mask = {4'h0, m_a}; v_rdata = {32'h0, rd_a};
    case (sel)
      2'd1: begin
        v_ready = rdy_b; v_valid = vld_b; v_fault = flt_b; v_breq = breq_b; v_bwe = bwe_b;
        v_addr  = addr_b; v_wdata = {32'h0, wd_b}; v_mask = {4'h0, m_b}; v_rdata = {32'h0, rd_b};
      end
      2'd2: begin
        v_ready = rdy_c; v_valid = vld_c; v_fault = flt_c; v_breq = breq_c; v_bwe = bwe_c;
        v_addr  = addr_c; v_wdata = wd_c; v_mask = m_c; v_rdata = rd_c;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    int cyc, beat, wcnt;
    bit got;
    @(negedge clk);
    sel = v.sel; req_we = v.we; req_width = v.width; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    #1 chk($sformatf("v%0d_ready_idle", idx), v_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1; beat = 0; wcnt = 0; got = 0;
    while (cyc <= 40 && !got) begin
      bus_ack = 1'b0;
      if (v_breq) begin
        chk($sformatf("v%0d_beat_in_range", idx), beat < v.beats, 1'b1);
        chk($sformatf("v%0d_ready_busy", idx), v_ready, 1'b0);
        chk($sformatf("v%0d_addr%0d", idx, beat), v_addr, (beat == 0) ? v.a0 : v.a1);
        chk($sformatf("v%0d_mask%0d", idx, beat), v_mask, (beat == 0) ? v.m0 : v.m1);
        chk($sformatf("v%0d_bwe%0d", idx, beat), v_bwe, v.we);
        if (v.we)
          chk($sformatf("v%0d_wdata%0d", idx, beat), v_wdata, (beat == 0) ? v.w0 : v.w1);
        if (wcnt == v.waits) begin
          bus_ack   = 1'b1;
          bus_rdata = (beat == 0) ? v.rd0 : v.rd1;
          wcnt = 0;
          beat++;
        end else begin
          wcnt++;
        end
      end
      if (v_valid) begin
        got = 1;
        chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.lat));
        chk($sformatf("v%0d_beats", idx), 64'(beat), 64'(v.beats));
        chk($sformatf("v%0d_fault", idx), v_fault, v.fault);
        chk($sformatf("v%0d_rdata", idx), v_rdata, v.rdata);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus_ack = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL v%0d_timeout: got no resp_valid want resp within 40 cycles", idx);
    end
    chk($sformatf("v%0d_resp_one_cycle", idx), v_valid, 1'b0);
    chk($sformatf("v%0d_ready_after", idx), v_ready, 1'b1);
  endtask

  initial begin
    //         sel   we    wd     uns   addr           wdata          rd0                    rd1                    wt bt a0             a1             m0     m1     w0                     w1          flt   rdata                  lat
    vecs[0]  = '{2'd0, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 64'h0,         64'h80FF_FF01,         64'h0,                 0, 1, 32'h0000_0100, 32'h0,         8'h08, 8'h00, 64'h0,                 64'h0,      1'b0, 64'hFFFF_FF80,         2};
    vecs[1]  = '{2'd0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 64'hBEEF,      64'h0,                 64'h0,                 0, 1, 32'h0000_0000, 32'h0,         8'h0C, 8'h00, 64'hBEEF_0000,         64'h0,      1'b0, 64'h0,                 2};
    vecs[2]  = '{2'd0, 1'b0, 2'b10, 1'b1, 32'h0000_00FE, 64'h0,         64'h1122_3344,         64'h5566_7788,         0, 2, 32'h0000_00FC, 32'h0000_0100, 8'h0C, 8'h03, 64'h0,                 64'h0,      1'b0, 64'h7788_1122,         3};
    vecs[3]  = '{2'd1, 1'b0, 2'b01, 1'b0, 32'h0000_0003, 64'h0,         64'h0,                 64'h0,                 0, 0, 32'h0,         32'h0,         8'h00, 8'h00, 64'h0,                 64'h0,      1'b1, 64'h0,                 1};
    vecs[4]  = '{2'd0, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 64'h0,         64'h0,                 64'h0,                 0, 0, 32'h0,         32'h0,         8'h00, 8'h00, 64'h0,                 64'h0,      1'b1, 64'h0,                 1};
    vecs[5]  = '{2'd2, 1'b0, 2'b10, 1'b0, 32'h0000_0007, 64'h0,         64'h1122_3344_5566_7788, 64'h0000_0000_00F2_3456, 3, 2, 32'h0000_0000, 32'h0000_0008, 8'h80, 8'h07, 64'h0,               64'h0,      1'b0, 64'hFFFF_FFFF_F234_5611, 9};
    vecs[6]  = '{2'd0, 1'b1, 2'b10, 1'b0, 32'h0000_0FFD, 64'hA1B2_C3D4, 64'h0,                 64'h0,                 1, 2, 32'h0000_0FFC, 32'h0000_1000, 8'h0E, 8'h01, 64'hB2C3_D400,         64'hA1,     1'b0, 64'h0,                 5};
    vecs[7]  = '{2'd0, 1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 64'h0,         64'hAB00_0000,         64'h0000_00CD,         0, 2, 32'hFFFF_FFFC, 32'h0000_0000, 8'h08, 8'h01, 64'h0,                 64'h0,      1'b0, 64'h0000_CDAB,         3};
    vecs[8]  = '{2'd2, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 64'h0,         64'h8000_0000_0000_0001, 64'h0,               0, 1, 32'h0000_0010, 32'h0,         8'hFF, 8'h00, 64'h0,                 64'h0,      1'b0, 64'h8000_0000_0000_0001, 2};
    vecs[9]  = '{2'd0, 1'b0, 2'b01, 1'b0, 32'h0000_0001, 64'h0,         64'h1280_0134,         64'h0,                 2, 1, 32'h0000_0000, 32'h0,         8'h06, 8'h00, 64'h0,                 64'h0,      1'b0, 64'hFFFF_8001,         4};
    vecs[10] = '{2'd1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 64'h0,         64'hCAFE_F00D,         64'h0,                 0, 1, 32'h0000_0020, 32'h0,         8'h0F, 8'h00, 64'h0,                 64'h0,      1'b0, 64'hCAFE_F00D,         2};
    vecs[11] = '{2'd2, 1'b1, 2'b00, 1'b0, 32'h0000_0005, 64'h5A,        64'h0,                 64'h0,                 0, 1, 32'h0000_0000, 32'h0,         8'h20, 8'h00, 64'h0000_5A00_0000_0000, 64'h0,    1'b0, 64'h0,                 2};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0; sel = 2'd0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("rst%0d_ready", s), v_ready, 1'b1);
      chk($sformatf("rst%0d_breq", s), v_breq, 1'b0);
      chk($sformatf("rst%0d_valid", s), v_valid, 1'b0);
      chk($sformatf("rst%0d_fault", s), v_fault, 1'b0);
      chk($sformatf("rst%0d_rdata", s), v_rdata, 64'h0);
      chk($sformatf("rst%0d_mask", s), v_mask, 8'h00);
    end
    @(negedge clk);
    reset = 1'b0;

    // Stray acks while idle must not start or finish anything.
    sel = 2'd0; bus_ack = 1'b1; bus_rdata = '1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ack_breq", v_breq, 1'b0);
      chk("idle_ack_valid", v_valid, 1'b0);
      chk("idle_ack_ready", v_ready, 1'b1);
    end
    bus_ack = 1'b0; bus_rdata = '0;

    for (int i = 0; i < 12; i++) do_txn(i, vecs[i]);

    // Reset while the spill beat is stalled: abandon without a response.
    @(negedge clk);
    sel = 2'd0; req_we = 1'b0; req_width = 2'b10; req_unsigned = 1'b1;
    req_addr = 32'h0000_00FE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    bus_ack = 1'b1; bus_rdata = 64'h1122_3344;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("rstmid_beat1_breq", v_breq, 1'b1);
    chk("rstmid_beat1_addr", v_addr, 32'h0000_0100);
    @(posedge clk); #1;
    chk("rstmid_beat1_hold", v_mask, 8'h03);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_breq", v_breq, 1'b0);
    chk("rstmid_ready", v_ready, 1'b1);
    chk("rstmid_valid", v_valid, 1'b0);
    chk("rstmid_mask", v_mask, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rstmid_no_resp", v_valid, 1'b0);
    end
    do_txn(100, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter XLEN, 32, SHALL set the data/bus width (32 or 64); bytes per bus word NB=XLEN/8.
REQ-003 Parameter ADDR_W, 32, SHALL set the address width.
REQ-004 Parameter SPLIT_MISALIGNED, 1, SHALL select 1 = split word-crossing accesses into two beats, 0 = report a fault.
REQ-005 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  clock, rising edge
 reset  in  1  asynchronous active-high reset
 req_valid  in  1  core request present
 req_ready  out  1  block accepts request
 req_we  in  1  1 = store, 0 = load
 req_width  in  2  00 byte, 01 half, 10 word, 11 double
 req_unsigned  in  1  zero-extend load
 req_addr  in  ADDR_W  byte address
 req_wdata  in  XLEN  store data, LSB-justified
 resp_valid  out  1  one-cycle completion pulse
 resp_rdata  out  XLEN  extended load data
 resp_fault  out  1  access rejected, valid with resp_valid
 bus_req  out  1  bus beat request
 bus_we  out  1  bus write
 bus_addr  out  ADDR_W  NB-aligned beat address
 bus_wdata  out  XLEN  lane-positioned write data
 bus_mask  out  NB  byte-lane enables
 bus_ack  in  1  beat complete; read data valid
 bus_rdata  in  XLEN  read data

Function
REQ-006 The FSM SHALL have states IDLE, BEAT0, BEAT1, RESP; req_ready SHALL equal (state==IDLE).
REQ-007 On req_valid&&req_ready, all request fields SHALL be registered; the next state SHALL be BEAT0, or RESP with fault set when the access is illegal.
REQ-008 Illegal: req_width=11 with XLEN=32; or an access crossing an NB boundary with SPLIT_MISALIGNED=0; no bus beat SHALL issue for an illegal access.
REQ-009 In BEAT0/BEAT1, bus_req SHALL be 1 and all bus outputs SHALL be held stable until the cycle bus_ack=1.
REQ-010 Offset off=addr mod NB, size sz=1<<width; beat0 bus_addr=addr with low log2(NB) bits cleared; beat1 bus_addr=beat0 address+NB, wrapping modulo 2^ADDR_W.
REQ-011 Beat0 mask SHALL be ((1<<sz)-1)<<off truncated to NB bits; beat1 mask SHALL be the bits shifted beyond NB, i.e. ((1<<sz)-1)>>(NB-off).
REQ-012 Beat0 wdata SHALL be wdata<<(8*off); beat1 wdata SHALL be wdata>>(8*(NB-off)).
REQ-013 BEAT0 with ack SHALL go to BEAT1 if off+sz>NB, else to RESP; BEAT1 with ack SHALL go to RESP.
REQ-014 Load data SHALL be assembled as (beat0_rdata>>(8*off)) | (beat1_rdata<<(8*(NB-off))), truncated to sz bytes, then sign-extended from bit 8*sz-1 or zero-extended per req_unsigned; for sz=XLEN/8 no extension SHALL apply.
REQ-015 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; resp_rdata SHALL be 0 for stores and faults.
REQ-016 Latency from acceptance to resp_valid SHALL be 1 + beats + total bus wait cycles; a zero-wait aligned access SHALL complete 2 cycles after acceptance.
REQ-017 bus_ack outside BEAT0/BEAT1 SHALL be ignored.
REQ-018 resp_valid has no backpressure; the next request SHALL be accepted no earlier than the IDLE cycle following RESP.

Reset
REQ-019 Reset SHALL force IDLE, req_ready=1, bus_req=0, resp_valid=0, resp_fault=0, resp_rdata=0, bus_mask=0 immediately, and SHALL abandon any in-flight transaction without a response.

Structure
REQ-020 Package lsu_pkg SHALL hold the width encoding enum, the FSM state enum and the NB/offset-width derivation functions.
REQ-021 Sub-module lsu_align SHALL be combinational and compute masks, write-lane shifting and load extension.

Verification
REQ-022 XLEN=32, load byte signed addr 0x103, bus_rdata 0x80FF_FF01 zero wait -> one beat addr 0x100, mask 1000, resp_rdata 0xFFFF_FF80, resp_valid 2 cycles after accept.
REQ-023 XLEN=32, store half 0xBEEF at 0x002 -> bus_addr 0x000, mask 1100, bus_wdata 0xBEEF_0000.
REQ-024 XLEN=32, SPLIT=1, load word unsigned addr 0x0FE, beat rdata 0x1122_3344 then 0x5566_7788 -> addrs 0x0FC/0x100, masks 1100/0011, resp_rdata 0x7788_1122.
REQ-025 SPLIT=0, load half at 0x003 -> no bus_req, resp_fault=1 next cycle; XLEN=32 width 11 -> same.
REQ-026 Reset asserted during BEAT1 with bus_ack held 0 -> bus_req drops at once, no resp_valid, req_ready=1; new request then completes normally.
REQ-027 XLEN=64, load word signed 0x007, 3-cycle bus_ack delay per beat -> two beats, masks 1000_0000/0000_0111, correct extension, resp_valid 9 cycles after accept.
